sram_port_arbiter: RTL
======================

# sram_port_arbiter

Controller for one 512 x 152-bit single-port SRAM macro with eight 19-bit write-mask lanes and a one-cycle registered read. It zero-fills the array after reset or on request, then arbitrates a read requester and a write requester onto the single RW port. Read data is returned through a two-entry response buffer with valid/ready backpressure. It sits between cache-side request logic and the SRAM macro wrapper.

## Interface
- DEPTH, 512, number of entries.
- ADDR_W, 9, address width, log2(DEPTH).
- DATA_W, 152, word width.
- MASK_W, 8, number of write-mask lanes; lane width is DATA_W/MASK_W = 19.

Ports:
- clock  in  1  sole clock; all state on its rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  one-cycle pulse; re-runs the zero-fill. Honoured only in RUN.
- init_done  out  1  high in RUN.
- rreq_valid / rreq_ready  in / out  1 / 1  read request handshake.
- rreq_addr  in  ADDR_W  read address.
- wreq_valid / wreq_ready  in / out  1 / 1  write request handshake.
- wreq_addr  in  ADDR_W  write address.
- wreq_mask  in  MASK_W  lane enables.
- wreq_data  in  DATA_W  write data.
- resp_valid / resp_ready  out / in  1 / 1  read response handshake.
- resp_data  out  DATA_W  read data, head of response buffer.
- sram_en, sram_wmode  out  1 each  macro enable and write mode.
- sram_addr  out  ADDR_W  macro address.
- sram_wmask  out  MASK_W  macro lane mask.
- sram_wdata  out  DATA_W  macro write data.
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read.

## Operation
- FSM states:
  - INIT sweeps addresses 0..DEPTH-1 at one per cycle with sram_en=1, wmode=1, wmask all ones, wdata=0. It moves to RUN after writing address DEPTH-1.
  - RUN arbitrates requests.
  - FLUSH_WAIT is entered from RUN on flush. It issues no new requests until no read is in flight, then moves to INIT.
- In INIT and FLUSH_WAIT, rreq_ready and wreq_ready are 0.
- Buffered responses survive a flush and are still delivered.
- In RUN, a request is eligible as follows:
  - Read: rreq_valid and read credit available. Credit means buffered entries + in-flight read - (resp_valid && resp_ready) < 2.
  - Write: wreq_valid.
- Only eligible requesters contend. If exactly one is eligible, it is granted.
- If both are eligible, round-robin applies. A one-bit last_grant flag is updated only on contested cycles, and the requester not granted last time wins. After reset, write wins first.
- Granting a requester drives its ready high and drives the SRAM port combinationally that cycle.
- Ready is a function of state, credit and the other requester's valid. It never depends on its own valid.
- Read grant sets in_flight. On the next cycle sram_rdata is pushed into the response buffer and in_flight clears.
- A write in the cycle after a read does not corrupt the captured data, because capture happens before the write is visible.
- Write-then-read to the same address returns the new data for masked-in lanes and the old data for the other lanes.
- Partial writes touch only lanes whose mask bit is 1. A mask of all zeros is still accepted and consumes the port for one cycle.
- Response buffer: 2-entry FIFO. resp_data is the head entry. Push and pop in the same cycle is allowed when not empty.
- sram_en=0 on idle cycles. sram_addr, sram_wmask and sram_wdata are 0 when sram_en=0.

## Timing
- Reset values: init_done=0, rreq_ready=0, wreq_ready=0, resp_valid=0, resp_data=0, sram_en=0.
- The state is INIT with the sweep address at 0 in the first cycle after reset deasserts.
- INIT lasts exactly DEPTH=512 cycles. init_done rises in cycle 512, counting the first INIT cycle as cycle 0.
- Read latency: request accepted in cycle t gives resp_valid=1 in cycle t+1 if the buffer was empty.
- Sustained read throughput is 1 per cycle while resp_ready=1.
- With resp_ready=0, at most 2 reads are outstanding. rreq_ready drops until a pop.
- Reset asserted mid-INIT, mid-read or with the buffer full: the next cycle everything returns to reset values, the buffer is discarded, and the sweep restarts at 0.
- flush while in INIT or FLUSH_WAIT is ignored.
- flush in the same cycle as a grant: the grant completes, and FLUSH_WAIT is entered the next cycle.

## Structure
- Shared package holds DEPTH, ADDR_W, DATA_W, MASK_W, the lane width and the state enum {INIT, RUN, FLUSH_WAIT}.
- Sub-module: sram_resp_fifo2, a 2-entry valid/ready FIFO of DATA_W with a count output used for credit.
- The FSM, sweep counter and arbiter live in the top module.

## Test plan
- Zero-fill: release reset. Check 512 consecutive zero writes to addresses 0..511, then init_done=1 at cycle 512. A read of address 37 returns 0.
- Lane masking: write address 5 with all-ones data and mask 0xFF, then write zeros with mask 0x01. Read address 5 returns bits [18:0]=0 and the rest all ones.
- Contention: hold rreq_valid and wreq_valid high for 6 cycles. Grants alternate W,R,W,R,W,R and never both in one cycle.
- Backpressure: resp_ready=0 with 4 reads queued. Exactly 2 are accepted and rreq_ready=0 after that. Raise resp_ready and the data arrive in order with no loss.
- Flush with buffered responses: 1 response buffered and 1 read in flight when flush is pulsed. Both responses are delivered, then a 512-cycle zero-fill runs, then a prior-written address reads 0.
- Reset mid-INIT at sweep address 200: the sweep restarts at 0, and resp_valid and init_done stay 0.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared sizing, state encoding and credit helper for the SRAM port arbiter.
package sram_port_arbiter_pkg;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 152;
    localparam int MASK_W = 8;
    localparam int LANE_W = DATA_W / MASK_W;
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_INIT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } arb_state_e;

    // A new read may issue only if everything already committed fits in two slots.
    function automatic logic read_credit(
        input logic [CNT_W-1:0] count,
        input logic             in_flight,
        input logic             pop
    );
        logic [CNT_W:0] occ;
        occ = {1'b0, count} + {{CNT_W{1'b0}}, in_flight} - {{CNT_W{1'b0}}, pop};
        return (occ < (CNT_W + 1)'(2));
    endfunction

endpackage

// File: rtl/sram_resp_fifo2.sv
// Two-entry fall-through response FIFO: an empty buffer passes the pushed word
// straight to the head so a read answers the cycle after it is granted.
module sram_resp_fifo2
    import sram_port_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              wr_ptr_d;
    logic              rd_ptr_q;
    logic              rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              empty_s;
    logic              pop_s;
    logic              store_s;
    logic              pop_mem_s;

    assign empty_s = (count_q == {CNT_W{1'b0}});
    assign valid_o = !empty_s || push_i;
    assign count_o = count_q;
    assign pop_s   = valid_o && pop_ready_i;

    // Head selection: stored entry first, else bypass, else zero.
    always_comb begin
        data_o = {DATA_W{1'b0}};
        if (!empty_s) begin
            data_o = mem_q[rd_ptr_q];
        end else if (push_i) begin
            data_o = push_data_i;
        end else begin
            data_o = {DATA_W{1'b0}};
        end
    end

    // Pointer and occupancy update; a bypassed word popped at once is never stored.
    always_comb begin
        store_s   = push_i && !(empty_s && pop_s) &&
                    ((count_q != CNT_W'(2)) || pop_s);
        pop_mem_s = pop_s && !empty_s;
        wr_ptr_d  = store_s ? !wr_ptr_q : wr_ptr_q;
        rd_ptr_d  = pop_mem_s ? !rd_ptr_q : rd_ptr_q;
        case ({store_s, pop_mem_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= {DATA_W{1'b0}};
            mem_q[1] <= {DATA_W{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (store_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM controller: zero-fill sweep, round-robin read/write
// arbitration onto the RW port, and a credited two-entry read response buffer.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    output logic              init_done,
    input  logic              rreq_valid,
    output logic              rreq_ready,
    input  logic [ADDR_W-1:0] rreq_addr,
    input  logic              wreq_valid,
    output logic              wreq_ready,
    input  logic [ADDR_W-1:0] wreq_addr,
    input  logic [MASK_W-1:0] wreq_mask,
    input  logic [DATA_W-1:0] wreq_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ADDR_W-1:0] sweep_q;
    logic [ADDR_W-1:0] sweep_d;
    logic              in_flight_q;
    logic              in_flight_d;
    logic              last_read_q;
    logic              last_read_d;

    logic [CNT_W-1:0]  fifo_count_s;
    logic              run_s;
    logic              sweep_s;
    logic              credit_s;
    logic              rd_elig_s;
    logic              contested_s;
    logic              rd_grant_s;
    logic              wr_grant_s;

    assign init_done = (state_q == ST_RUN);
    // Reset gates the port so a held reset never sweeps or grants.
    assign run_s     = (state_q == ST_RUN) && !reset;
    assign sweep_s   = (state_q == ST_INIT) && !reset;
    assign credit_s  = read_credit(fifo_count_s, in_flight_q, resp_valid && resp_ready);
    assign rd_elig_s = rreq_valid && credit_s;

    // Readies look only at state, credit and the opposing valid; last_read_q
    // set means write wins the next contested cycle.
    assign rreq_ready  = run_s && credit_s && (!wreq_valid || !last_read_q);
    assign wreq_ready  = run_s && (!rd_elig_s || last_read_q);
    assign rd_grant_s  = rreq_ready && rreq_valid;
    assign wr_grant_s  = wreq_ready && wreq_valid;
    assign contested_s = run_s && rd_elig_s && wreq_valid;

    // Next-state for the FSM, sweep counter, in-flight flag and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        in_flight_d = rd_grant_s;
        if (contested_s) begin
            last_read_d = rd_grant_s;
        end else begin
            last_read_d = last_read_q;
        end
        case (state_q)
            ST_INIT: begin
                if (sweep_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    sweep_d = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_INIT;
                    sweep_d = sweep_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!in_flight_q) begin
                    state_d = ST_INIT;
                    sweep_d = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_q     <= {ADDR_W{1'b0}};
            in_flight_q <= 1'b0;
            last_read_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            in_flight_q <= in_flight_d;
            last_read_q <= last_read_d;
        end
    end

    // SRAM port mux: sweep, granted write, granted read, or idle with zeros.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = {ADDR_W{1'b0}};
        sram_wmask = {MASK_W{1'b0}};
        sram_wdata = {DATA_W{1'b0}};
        if (sweep_s) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_q;
            sram_wmask = {MASK_W{1'b1}};
        end else if (wr_grant_s) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wreq_addr;
            sram_wmask = wreq_mask;
            sram_wdata = wreq_data;
        end else if (rd_grant_s) begin
            sram_en    = 1'b1;
            sram_addr  = rreq_addr;
        end else begin
            sram_en    = 1'b0;
            sram_wmode = 1'b0;
        end
    end

    sram_resp_fifo2 u_resp_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (in_flight_q),
        .push_data_i (sram_rdata),
        .pop_ready_i (resp_ready),
        .valid_o     (resp_valid),
        .data_o      (resp_data),
        .count_o     (fifo_count_s)
    );

endmodule
